// File: rtl/tx_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_frame_sequencer                                                       |
// | Drains TX FIFO bytes and sends each as a start/data/stop serial frame.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tx_frame_sequencer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [DIV_W-1:0]  baud_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_pop_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              tx_done_o
);
    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              can_load;
    logic              load;

    assign bit_end  = (baud_cnt_q == div_q);
    // Reset is folded in so a pop can never escape during reset.
    assign can_load = enable_i && !fifo_empty_i && !reset_i;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        div_d      = div_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;
        load       = 1'b0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                load = can_load;
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d     = 1'b1;
                    baud_cnt_d = '0;
                    load       = can_load;
                    if (!can_load) begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d    = START;
            shift_d    = fifo_data_i;
            div_d      = baud_i;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
        end

        // Line level is derived from the next state so TX is registered yet aligned.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            div_q      <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_pop_o = load;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign tx_done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tx_frame_sequencer                                                    |
// | Directed self-checking bench for tx_frame_sequencer.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_tx_frame_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] baud;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int         checks = 0;
    int         errors = 0;
    int         pops   = 0;
    int         dones  = 0;
    logic [7:0] fifo_q[$];

    always #5 clk = ~clk;

    tx_frame_sequencer #(
        .DATA_W(8),
        .DIV_W (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .enable_i    (enable),
        .baud_i      (baud),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i (fifo_data),
        .fifo_pop_o  (fifo_pop),
        .tx_o        (tx),
        .busy_o      (busy),
        .tx_done_o   (tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    // Advance one cycle; returns at negedge+1 of the new cycle.
    task automatic step();
        logic p;
        #1;
        p = fifo_pop;
        @(posedge clk);
        if (p === 1'b1) begin
            pops++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        @(negedge clk);
        refresh();
        #1;
        if (tx_done === 1'b1) dones++;
    endtask

    // bits[0] is the start bit, bits[9] the stop bit; each held bp cycles.
    task automatic check_frame(input string tag, input logic [9:0] bits, input int bp,
                               input logic done_first);
        for (int i = 0; i < 10 * bp; i++) begin
            step();
            chk({tag, "_tx"}, 32'(tx), 32'(bits[i / bp]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_done"}, 32'(tx_done), (i == 0) ? 32'(done_first) : 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;

        reset  = 1'b1;
        enable = 1'b0;
        baud   = 8'd0;
        refresh();
        repeat (3) step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_pop", 32'(fifo_pop), 32'd0);
        reset = 1'b0;
        step();

        // Single 0xA5 frame at 4 cycles/bit
        baud   = 8'd3;
        enable = 1'b1;
        fifo_q.push_back(8'hA5);
        refresh();
        #1;
        chk("a5_pop", 32'(fifo_pop), 32'd1);
        check_frame("a5", 10'b1_10100101_0, 4, 1'b0);
        chk("a5_nopop", 32'(fifo_pop), 32'd0);
        step();
        chk("a5_done", 32'(tx_done), 32'd1);
        chk("a5_idle_tx", 32'(tx), 32'd1);
        chk("a5_idle_busy", 32'(busy), 32'd0);
        step();
        chk("a5_done_clr", 32'(tx_done), 32'd0);
        chk("a5_pops", 32'(pops), 32'd1);

        // Back-to-back 0x00, 0xFF at 1 cycle/bit
        p0   = pops;
        d0   = dones;
        baud = 8'd0;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        refresh();
        #1;
        chk("b2b_pop0", 32'(fifo_pop), 32'd1);
        check_frame("b2b0", 10'b1_00000000_0, 1, 1'b0);
        chk("b2b_pop1", 32'(fifo_pop), 32'd1);
        check_frame("b2b1", 10'b1_11111111_0, 1, 1'b1);
        chk("b2b_nopop", 32'(fifo_pop), 32'd0);
        step();
        chk("b2b_done", 32'(tx_done), 32'd1);
        chk("b2b_busy_end", 32'(busy), 32'd0);
        chk("b2b_pops", 32'(pops - p0), 32'd2);
        chk("b2b_dones", 32'(dones - d0), 32'd2);

        // BAUD change and ENABLE drop mid-frame
        baud = 8'd3;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        refresh();
        #1;
        chk("mid_pop", 32'(fifo_pop), 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin
                baud   = 8'd7;
                enable = 1'b0;
            end
            step();
            chk("mid_tx", 32'(tx), 32'(10'b1_00010001_0 >> (i / 4)) & 32'd1);
            chk("mid_busy", 32'(busy), 32'd1);
        end
        chk("mid_nopop_last", 32'(fifo_pop), 32'd0);
        step();
        chk("mid_done", 32'(tx_done), 32'd1);
        chk("mid_busy_end", 32'(busy), 32'd0);
        p0 = pops;
        repeat (20) begin
            step();
            chk("dis_pop", 32'(fifo_pop), 32'd0);
            chk("dis_tx", 32'(tx), 32'd1);
        end
        chk("dis_pops", 32'(pops - p0), 32'd0);
        enable = 1'b1;
        #1;
        chk("reen_pop", 32'(fifo_pop), 32'd1);
        check_frame("b8", 10'b1_00100010_0, 8, 1'b0);
        step();
        chk("b8_done", 32'(tx_done), 32'd1);
        chk("b8_busy_end", 32'(busy), 32'd0);

        // Reset during data bit 3 of 0x5A
        baud = 8'd3;
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h33);
        refresh();
        #1;
        chk("rmid_pop", 32'(fifo_pop), 32'd1);
        repeat (18) step();
        chk("rmid_bit3", 32'(tx), 32'd1);
        chk("rmid_busy", 32'(busy), 32'd1);
        d0    = dones;
        reset = 1'b1;
        #1;
        chk("rmid_pop_rst", 32'(fifo_pop), 32'd0);
        step();
        chk("rmid_tx", 32'(tx), 32'd1);
        chk("rmid_busy0", 32'(busy), 32'd0);
        chk("rmid_done", 32'(tx_done), 32'd0);
        chk("rmid_pop_idle_rst", 32'(fifo_pop), 32'd0);
        step();
        chk("rmid_pop_idle_rst2", 32'(fifo_pop), 32'd0);
        reset = 1'b0;
        #1;
        chk("rrel_pop", 32'(fifo_pop), 32'd1);
        check_frame("r33", 10'b1_00110011_0, 4, 1'b0);
        step();
        chk("r33_done", 32'(tx_done), 32'd1);
        chk("r33_dones", 32'(dones - d0), 32'd1);

        // Empty FIFO for 100 cycles, then 0x81 at BAUD=255
        baud = 8'd255;
        p0   = pops;
        repeat (100) begin
            step();
            chk("empty_pop", 32'(fifo_pop), 32'd0);
            chk("empty_tx", 32'(tx), 32'd1);
            chk("empty_busy", 32'(busy), 32'd0);
        end
        chk("empty_pops", 32'(pops - p0), 32'd0);
        fifo_q.push_back(8'h81);
        refresh();
        #1;
        chk("b256_pop", 32'(fifo_pop), 32'd1);
        check_frame("b256", 10'b1_10000001_0, 256, 1'b0);
        step();
        chk("b256_done", 32'(tx_done), 32'd1);
        chk("b256_busy_end", 32'(busy), 32'd0);
        chk("b256_tx_idle", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
